// File: rtl/pulse_param_loader.sv
// pulse_param_loader
// Decodes framed write commands arriving from the UART receiver, updates the
// pulse timing registers atomically on a good checksum, pulses rx_done so the
// sequencer restarts, and answers each frame with ACK (0x06) or NAK (0x15).
//
// Frame: CMD, N data bytes (MSB first), CSUM = XOR of CMD and data bytes.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a command byte
// DATA   | shifting data bytes into the shadow register
// CSUM   | waiting for the checksum byte; commit on match
// RESP   | holding the ACK/NAK byte until the transmitter is free
module pulse_param_loader #(
    parameter int unsigned TIMEOUT     = 1200000,
    parameter int unsigned ST_PERIOD   = 262144,
    parameter int unsigned ST_P1WIDTH  = 30,
    parameter int unsigned ST_DELAY    = 200,
    parameter int unsigned ST_P2WIDTH  = 60,
    parameter int unsigned ST_NUTDEL   = 100,
    parameter int unsigned ST_NUTWID   = 100,
    parameter int unsigned ST_BLOCK    = 50,
    parameter int unsigned ST_BLOCKOFF = 100,
    parameter int unsigned ST_CPMG     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    output logic [31:0] period,
    output logic [15:0] p1width,
    output logic [15:0] delay,
    output logic [15:0] p2width,
    output logic [15:0] nut_del,
    output logic [15:0] pulse_block_off,
    output logic [7:0]  nut_wid,
    output logic [7:0]  pulse_block,
    output logic [7:0]  cpmg,
    output logic        block,
    output logic        rx_done,
    output logic        frame_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CSUM = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [7:0]  BYTE_ACK = 8'h06;
    localparam logic [7:0]  BYTE_NAK = 8'h15;
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

    // Number of data bytes carried by each command; zero marks an unknown command.
    function automatic logic [2:0] cmd_len(input logic [7:0] cmd);
        logic [2:0] len;
        len = 3'd0;
        case (cmd)
            8'h01:                      len = 3'd4;
            8'h02, 8'h03, 8'h04, 8'h05,
            8'h08:                      len = 3'd2;
            8'h06, 8'h07, 8'h09, 8'h0A: len = 3'd1;
            default:                    len = 3'd0;
        endcase
        return len;
    endfunction

    logic [1:0]  r_state;
    logic [7:0]  r_cmd;
    logic [2:0]  r_cnt;
    logic [7:0]  r_xor;
    logic [31:0] r_shadow;
    logic [31:0] r_to_cnt;
    logic [7:0]  r_tx_byte;
    logic        r_rx_done;
    logic        r_frame_err;

    logic [31:0] r_period;
    logic [15:0] r_p1width;
    logic [15:0] r_delay;
    logic [15:0] r_p2width;
    logic [15:0] r_nut_del;
    logic [15:0] r_pulse_block_off;
    logic [7:0]  r_nut_wid;
    logic [7:0]  r_pulse_block;
    logic [7:0]  r_cpmg;
    logic        r_block;

    logic [2:0]  w_len;
    logic        w_in_frame;
    logic        w_timeout;
    logic        w_commit;

    assign w_len      = cmd_len(rx_byte);
    assign w_in_frame = (r_state == S_DATA) || (r_state == S_CSUM);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout  = w_in_frame && !rx_valid && (r_to_cnt == TO_LAST);
    assign w_commit   = (r_state == S_CSUM) && rx_valid && (rx_byte == r_xor);

    // Frame parser: state, byte counter, running checksum, shadow, response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cmd       <= 8'h00;
            r_cnt       <= 3'd0;
            r_xor       <= 8'h00;
            r_shadow    <= 32'h0;
            r_tx_byte   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (w_len != 3'd0) begin
                            r_cmd    <= rx_byte;
                            r_cnt    <= w_len;
                            r_xor    <= rx_byte;
                            r_shadow <= 32'h0;
                            r_state  <= S_DATA;
                        end else begin
                            r_tx_byte   <= BYTE_NAK;
                            r_frame_err <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_shadow <= {r_shadow[23:0], rx_byte};
                        r_xor    <= r_xor ^ rx_byte;
                        r_cnt    <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) begin
                            r_state <= S_CSUM;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        if (w_commit) begin
                            r_rx_done <= 1'b1;
                            r_tx_byte <= BYTE_ACK;
                        end else begin
                            r_tx_byte   <= BYTE_NAK;
                            r_frame_err <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_RESP: begin
                    // Bytes received here are dropped; leave once the response goes out.
                    if (!tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Inter-byte silence counter, only running while a frame is open.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= 32'h0;
        end else if (!w_in_frame || rx_valid || w_timeout) begin
            r_to_cnt <= 32'h0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    // Parameter registers: loaded from the shadow only on a verified checksum.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_period          <= 32'(ST_PERIOD);
            r_p1width         <= 16'(ST_P1WIDTH);
            r_delay           <= 16'(ST_DELAY);
            r_p2width         <= 16'(ST_P2WIDTH);
            r_nut_del         <= 16'(ST_NUTDEL);
            r_nut_wid         <= 8'(ST_NUTWID);
            r_pulse_block     <= 8'(ST_BLOCK);
            r_pulse_block_off <= 16'(ST_BLOCKOFF);
            r_cpmg            <= 8'(ST_CPMG);
            r_block           <= 1'b1;
        end else if (w_commit) begin
            case (r_cmd)
                8'h01:   r_period          <= r_shadow;
                8'h02:   r_p1width         <= r_shadow[15:0];
                8'h03:   r_delay           <= r_shadow[15:0];
                8'h04:   r_p2width         <= r_shadow[15:0];
                8'h05:   r_nut_del         <= r_shadow[15:0];
                8'h06:   r_nut_wid         <= r_shadow[7:0];
                8'h07:   r_pulse_block     <= r_shadow[7:0];
                8'h08:   r_pulse_block_off <= r_shadow[15:0];
                8'h09:   r_cpmg            <= r_shadow[7:0];
                8'h0A:   r_block           <= r_shadow[0];
                default: ;
            endcase
        end
    end

    assign tx_start        = (r_state == S_RESP) && !tx_busy;
    assign tx_byte         = r_tx_byte;
    assign rx_done         = r_rx_done;
    assign frame_err       = r_frame_err;
    assign period          = r_period;
    assign p1width         = r_p1width;
    assign delay           = r_delay;
    assign p2width         = r_p2width;
    assign nut_del         = r_nut_del;
    assign pulse_block_off = r_pulse_block_off;
    assign nut_wid         = r_nut_wid;
    assign pulse_block     = r_pulse_block;
    assign cpmg            = r_cpmg;
    assign block           = r_block;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Testbench for pulse_param_loader: directed frames plus randomized frames
// checked against a register-level model of the command set.
module tb_pulse_param_loader;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        tx_busy;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic [31:0] period;
    logic [15:0] p1width, delay, p2width, nut_del, pulse_block_off;
    logic [7:0]  nut_wid, pulse_block, cpmg;
    logic        block, rx_done, frame_err;

    int n_cmp = 0;
    int n_err = 0;

    pulse_param_loader #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_byte(tx_byte), .tx_start(tx_start),
        .period(period), .p1width(p1width), .delay(delay), .p2width(p2width),
        .nut_del(nut_del), .pulse_block_off(pulse_block_off), .nut_wid(nut_wid),
        .pulse_block(pulse_block), .cpmg(cpmg), .block(block),
        .rx_done(rx_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [136:0] w_regs;
    assign w_regs = {period, p1width, delay, p2width, nut_del, pulse_block_off,
                     nut_wid, pulse_block, cpmg, block};

    // Reference model: the visible register file.
    logic [31:0] m_period;
    logic [15:0] m_p1, m_delay, m_p2, m_nutdel, m_blkoff;
    logic [7:0]  m_nutwid, m_blk, m_cpmg;
    logic        m_block;
    int          len_tab [11] = '{0, 4, 2, 2, 2, 2, 1, 1, 2, 1, 1};

    function automatic logic [136:0] m_pack();
        return {m_period, m_p1, m_delay, m_p2, m_nutdel, m_blkoff,
                m_nutwid, m_blk, m_cpmg, m_block};
    endfunction

    task automatic model_reset();
        m_period = 32'd262144; m_p1 = 16'd30; m_delay = 16'd200; m_p2 = 16'd60;
        m_nutdel = 16'd100; m_nutwid = 8'd100; m_blk = 8'd50; m_blkoff = 16'd100;
        m_cpmg = 8'd4; m_block = 1'b1;
    endtask

    task automatic model_apply(input logic [7:0] cmd, input logic [31:0] value);
        case (cmd)
            8'h01: m_period = value;
            8'h02: m_p1     = value[15:0];
            8'h03: m_delay  = value[15:0];
            8'h04: m_p2     = value[15:0];
            8'h05: m_nutdel = value[15:0];
            8'h06: m_nutwid = value[7:0];
            8'h07: m_blk    = value[7:0];
            8'h08: m_blkoff = value[15:0];
            8'h09: m_cpmg   = value[7:0];
            8'h0A: m_block  = value[0];
            default: ;
        endcase
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        resetn   = 1'b0;
        model_reset();
        idle(2);
        resetn = 1'b1;
        idle(1);
    endtask

    // Sends CMD, the low bytes of data (MSB first) and a checksum, optionally
    // corrupted; updates the model only for a good frame.
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] data,
                              input logic bad);
        int          n;
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] acc;
        n   = len_tab[cmd];
        cs  = cmd;
        acc = 32'd0;
        send_byte(cmd);
        for (int i = n - 1; i >= 0; i--) begin
            b   = 8'((data >> (8 * i)) & 32'hFF);
            acc = acc * 256 + 32'(b);
            cs  = cs ^ b;
            send_byte(b);
        end
        if (bad) cs = cs ^ 8'($urandom_range(1, 255));
        else     model_apply(cmd, acc);
        send_byte(cs);
    endtask

    task automatic test_reset();
        model_reset();
        n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL reset_regs: got %h exp %h", w_regs, m_pack()); end
        n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_rx_done: got %b exp 0", rx_done); end
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b exp 0", tx_start); end
        n_cmp++; if (tx_byte !== 8'h00) begin n_err++; $display("FAIL reset_tx_byte: got %h exp 00", tx_byte); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
    endtask

    task automatic test_p1width();
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h2C);
        n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL p1w_midframe: got %h exp %h", w_regs, m_pack()); end
        send_byte(8'h2F);
        model_apply(8'h02, 32'd1 * 256 + 32'h2C);
        n_cmp++; if (p1width !== 16'd300) begin n_err++; $display("FAIL p1w_value: got %0d exp 300", p1width); end
        n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL p1w_regs: got %h exp %h", w_regs, m_pack()); end
        n_cmp++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL p1w_rx_done: got %b exp 1", rx_done); end
        n_cmp++; if (tx_start !== 1'b1 || tx_byte !== 8'h06) begin n_err++; $display("FAIL p1w_ack: got start=%b byte=%h exp 1/06", tx_start, tx_byte); end
        idle(1);
        n_cmp++; if (rx_done !== 1'b0 || tx_start !== 1'b0) begin n_err++; $display("FAIL p1w_one_cycle: got done=%b start=%b exp 0/0", rx_done, tx_start); end
    endtask

    task automatic test_period_ack();
        send_frame(8'h01, 32'h0008_0000, 1'b0);
        n_cmp++; if (period !== 32'h0008_0000) begin n_err++; $display("FAIL period_value: got %h exp 00080000", period); end
        n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL period_regs: got %h exp %h", w_regs, m_pack()); end
        n_cmp++; if (rx_done !== 1'b1 || tx_byte !== 8'h06) begin n_err++; $display("FAIL period_ack: got done=%b byte=%h exp 1/06", rx_done, tx_byte); end
        idle(1);
    endtask

    task automatic test_timeout_boundary();
        send_byte(8'h03);
        send_byte(8'h01);
        idle(TO - 1);
        send_byte(8'h02);
        send_byte(8'h03 ^ 8'h01 ^ 8'h02);
        model_apply(8'h03, 32'h0102);
        n_cmp++; if (rx_done !== 1'b1 || tx_byte !== 8'h06) begin n_err++; $display("FAIL late_byte_ack: got done=%b byte=%h exp 1/06", rx_done, tx_byte); end
        n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL late_byte_regs: got %h exp %h", w_regs, m_pack()); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL late_byte_err: got %b exp 0", frame_err); end
        idle(1);
    endtask

    task automatic test_timeout();
        logic saw;
        do_reset();
        saw = 1'b0;
        send_byte(8'h03);
        send_byte(8'h01);
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            if (tx_start || rx_done) saw = 1'b1;
        end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL timeout_early: got err=%b exp 0", frame_err); end
        @(negedge clk);
        if (tx_start || rx_done) saw = 1'b1;
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b exp 1", frame_err); end
        idle(3);
        if (tx_start || rx_done) saw = 1'b1;
        n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL timeout_quiet: got activity=%b exp 0", saw); end
        n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL timeout_regs: got %h exp %h", w_regs, m_pack()); end
        send_frame(8'h04, 32'h007B, 1'b0);
        n_cmp++; if (rx_done !== 1'b1 || w_regs !== m_pack()) begin n_err++; $display("FAIL timeout_recover: got done=%b regs=%h exp 1/%h", rx_done, w_regs, m_pack()); end
        idle(1);
    endtask

    task automatic test_bad_csum();
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h0A);
        n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL badcs_regs: got %h exp %h", w_regs, m_pack()); end
        n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL badcs_rx_done: got %b exp 0", rx_done); end
        n_cmp++; if (tx_start !== 1'b1 || tx_byte !== 8'h15) begin n_err++; $display("FAIL badcs_nak: got start=%b byte=%h exp 1/15", tx_start, tx_byte); end
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL badcs_err: got %b exp 1", frame_err); end
        idle(1);
    endtask

    task automatic test_bad_cmd();
        do_reset();
        send_byte(8'h0C);
        n_cmp++; if (tx_start !== 1'b1 || tx_byte !== 8'h15) begin n_err++; $display("FAIL badcmd_nak: got start=%b byte=%h exp 1/15", tx_start, tx_byte); end
        n_cmp++; if (frame_err !== 1'b1 || rx_done !== 1'b0) begin n_err++; $display("FAIL badcmd_flags: got err=%b done=%b exp 1/0", frame_err, rx_done); end
        idle(1);
        send_byte(8'h09); send_byte(8'h08); send_byte(8'h01);
        model_apply(8'h09, 32'd8);
        n_cmp++; if (cpmg !== 8'd8 || w_regs !== m_pack()) begin n_err++; $display("FAIL badcmd_next: got cpmg=%0d regs=%h exp 8/%h", cpmg, w_regs, m_pack()); end
        n_cmp++; if (tx_byte !== 8'h06) begin n_err++; $display("FAIL badcmd_next_ack: got %h exp 06", tx_byte); end
        idle(1);
        send_byte(8'h00);
        n_cmp++; if (tx_start !== 1'b1 || tx_byte !== 8'h15) begin n_err++; $display("FAIL zerocmd_nak: got start=%b byte=%h exp 1/15", tx_start, tx_byte); end
        idle(1);
    endtask

    task automatic test_random();
        logic [7:0]  cmd;
        logic [31:0] data;
        logic        bad;
        int          errs;
        errs = 0;
        for (int f = 0; f < 40; f++) begin
            cmd  = 8'($urandom_range(1, 10));
            data = $urandom();
            bad  = ($urandom_range(0, 3) == 0);
            send_frame(cmd, data, bad);
            n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL rnd_regs[%0d] cmd %h: got %h exp %h", f, cmd, w_regs, m_pack()); end
            n_cmp++; if (rx_done !== !bad) begin n_err++; $display("FAIL rnd_done[%0d]: got %b exp %b", f, rx_done, !bad); end
            n_cmp++; if (tx_start !== 1'b1 || tx_byte !== (bad ? 8'h15 : 8'h06)) begin n_err++; $display("FAIL rnd_resp[%0d]: got start=%b byte=%h bad=%b", f, tx_start, tx_byte, bad); end
            idle($urandom_range(1, 3));
        end
    endtask

    task automatic test_tx_busy();
        logic saw;
        do_reset();
        saw = 1'b0;
        tx_busy = 1'b1;
        send_frame(8'h07, 32'h33, 1'b0);
        n_cmp++; if (rx_done !== 1'b1 || pulse_block !== 8'h33) begin n_err++; $display("FAIL busy_commit: got done=%b blk=%h exp 1/33", rx_done, pulse_block); end
        for (int i = 0; i < 50; i++) begin
            if (tx_start) saw = 1'b1;
            if (i == 10) send_byte(8'h02);
            else if (i == 11) send_byte(8'h05);
            else @(negedge clk);
        end
        n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL busy_hold: got start seen=%b exp 0", saw); end
        tx_busy = 1'b0;
        #1;
        n_cmp++; if (tx_start !== 1'b1 || tx_byte !== 8'h06) begin n_err++; $display("FAIL busy_release: got start=%b byte=%h exp 1/06", tx_start, tx_byte); end
        @(negedge clk);
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL busy_once: got %b exp 0", tx_start); end
        send_frame(8'h09, 32'h03, 1'b0);
        n_cmp++; if (rx_done !== 1'b1 || w_regs !== m_pack()) begin n_err++; $display("FAIL busy_discard: got done=%b regs=%h exp 1/%h", rx_done, w_regs, m_pack()); end
        idle(1);
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h02, 32'h0777, 1'b0);
        idle(1);
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        resetn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (w_regs !== m_pack()) begin n_err++; $display("FAIL midrst_regs: got %h exp %h", w_regs, m_pack()); end
        n_cmp++; if (frame_err !== 1'b0 || rx_done !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got err=%b done=%b exp 0/0", frame_err, rx_done); end
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        send_frame(8'h02, 32'h0005, 1'b0);
        n_cmp++; if (w_regs !== m_pack() || rx_done !== 1'b1) begin n_err++; $display("FAIL midrst_fresh: got regs=%h done=%b exp %h/1", w_regs, rx_done, m_pack()); end
        idle(1);
    endtask

    initial begin
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_p1width();
        test_period_ack();
        test_timeout_boundary();
        test_timeout();
        test_bad_csum();
        test_bad_cmd();
        test_random();
        test_tx_busy();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pulse_param_loader.md
# pulse_param_loader

Serial command decoder that configures the pulse generator. It consumes bytes from the UART receiver and parses framed write commands. It updates the timing-parameter registers (period, widths, delays, nutation, blanking, CPMG count, block enable) atomically, pulses `rx_done` so the pulse sequencer restarts with the new values, and returns an ACK/NAK byte through the UART transmitter. It sits between the UART pair and the `pulses` sequencer in the top level.

## Interface
Parameters:
- `TIMEOUT`, 1200000: idle cycles allowed between bytes of one frame (100 ms at 12 MHz).
- `ST_PERIOD`, 262144: reset value of `period`.
- `ST_P1WIDTH`, 30: reset value of `p1width`.
- `ST_DELAY`, 200: reset value of `delay`.
- `ST_P2WIDTH`, 60: reset value of `p2width`.
- `ST_NUTDEL`, 100 and `ST_NUTWID`, 100: reset values of `nut_del` and `nut_wid`.
- `ST_BLOCK`, 50 and `ST_BLOCKOFF`, 100: reset values of `pulse_block` and `pulse_block_off`.
- `ST_CPMG`, 4: reset value of `cpmg`.

Ports:
- `clk`, in, 1: single clock, 12 MHz.
- `resetn`, in, 1: asynchronous, active-low reset.
- `rx_byte`, in, 8: received byte.
- `rx_valid`, in, 1: one-cycle strobe; `rx_byte` is valid in that cycle.
- `tx_busy`, in, 1: transmitter is occupied.
- `tx_byte`, out, 8: response byte.
- `tx_start`, out, 1: one-cycle transmit request.
- `period`, out, 32: pulse period.
- `p1width`, `delay`, `p2width`, `nut_del`, `pulse_block_off`, out, 16 each: pulse widths and delays.
- `nut_wid`, `pulse_block`, `cpmg`, out, 8 each: nutation width, blanking width, CPMG count.
- `block`, out, 1: block enable.
- `rx_done`, out, 1: one-cycle pulse on each committed write.
- `frame_err`, out, 1: sticky error flag; cleared only by reset.

## Operation
- Frame format: CMD, then N data bytes (MSB first), then CSUM. CSUM is the XOR of CMD and all data bytes.
- CMD map and N:
  - 0x01 `period` (4)
  - 0x02 `p1width` (2)
  - 0x03 `delay` (2)
  - 0x04 `p2width` (2)
  - 0x05 `nut_del` (2)
  - 0x06 `nut_wid` (1)
  - 0x07 `pulse_block` (1)
  - 0x08 `pulse_block_off` (2)
  - 0x09 `cpmg` (1)
  - 0x0A `block` (1; only bit 0 is used, other bits are ignored)
- Data bytes shift into a 32-bit shadow register. The targeted output takes the low N×8 bits. Outputs never change mid-frame.
- FSM states: IDLE, DATA, CSUM, RESP.
- IDLE:
  - `rx_valid` with a valid CMD: latch CMD, load byte counter = N, running XOR = CMD, go to DATA.
  - Invalid CMD (0x00 or ≥0x0B): `tx_byte`=0x15 (NAK), set `frame_err`, go to RESP.
- DATA: each `rx_valid` shifts in a byte, XORs it into the running XOR and decrements the counter. On the last byte, go to CSUM.
- CSUM, on `rx_valid`:
  - Byte matches the running XOR: commit the shadow to the target register, assert `rx_done`, `tx_byte`=0x06 (ACK).
  - Mismatch: no register change, `tx_byte`=0x15, set `frame_err`.
  - Either way, go to RESP.
- RESP: assert `tx_start` in the first cycle with `tx_busy`=0, then return to IDLE. `rx_valid` bytes arriving in RESP are discarded.
- Timeout:
  - In DATA/CSUM, an inter-byte counter resets on each `rx_valid`.
  - When the counter reaches `TIMEOUT`-1 with no byte: abandon the frame, set `frame_err`, go to IDLE, send nothing.
  - The counter is held at 0 in IDLE and RESP.

## Timing
- Reset (asynchronous, `resetn`=0): every parameter output takes its `ST_*` value; `block`=1; `rx_done`=0, `tx_start`=0, `tx_byte`=0x00, `frame_err`=0; FSM=IDLE; counters 0.
- A byte is accepted on the rising edge where `rx_valid`=1.
- Commit: CSUM byte sampled at edge k. The new register value and `rx_done`=1 are visible from edge k to k+1. `rx_done` is high for exactly 1 cycle.
- `tx_start` is high for exactly one cycle: the first cycle in RESP with `tx_busy`=0, earliest k to k+1. With `tx_busy` held high, the FSM waits in RESP indefinitely.
- Latency from CSUM byte to register update: 1 cycle.
- `rx_valid` in the same cycle as timeout expiry: the byte wins, it is accepted and the counter resets.
- Back-to-back frames: a CMD byte arriving in the cycle the FSM returns to IDLE is accepted.
- Reset asserted mid-frame: the partial frame is discarded, and registers return to their `ST_*` values, not to the last committed values.

## Test plan
- Reset release → `period`=262144, `p1width`=30, `delay`=200, `p2width`=60, `cpmg`=4, `block`=1, `rx_done`=0.
- Frame 0x02,0x01,0x2C,0x2F → `p1width`=300 one cycle after CSUM; `rx_done` pulses once; `tx_start` with `tx_byte`=0x06; all other registers unchanged.
- Frame 0x01,0x00,0x08,0x00,0x00,0x09 → `period`=0x00080000, ACK. Same frame with CSUM 0x0A → `period` unchanged, NAK, `frame_err`=1, no `rx_done`.
- CMD 0x0C → immediate NAK. Following byte 0x09 is then parsed as a fresh CMD: frame 0x09,0x08,0x01 → `cpmg`=8.
- Partial frame 0x03,0x01, then silence for `TIMEOUT` cycles → `delay` unchanged, `frame_err`=1, no `tx_start`. A new frame is accepted afterwards.
- `tx_busy` held high for 50 cycles after a good CSUM → `tx_start` asserted in the cycle after `tx_busy` falls. Bytes sent during the wait are ignored. `resetn` pulsed mid-frame restores all `ST_*` values.
